multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
// - Moore FSM sequencing the multi-cycle MIPS datapath: drives load enables of PC, IR, MDR, A/B, ALUOut
//   registers, memory strobes, register-file write and mux selects. Sits beside the datapath in the CPU top.
// - Inserts MEM_LAT-cycle memory waits on fetch, load and store; reports done/illegal per instruction.
// PARAMETERS
// - MEM_LAT  1  memory access cycles (>=1); FETCH/MEMRD/MEMWR each last MEM_LAT cycles
// - CNT_W    4  width of wait counter; must hold MEM_LAT-1
// PORTS
// - clk          in   1  clock, rising edge
// - rst          in   1  synchronous, active-low reset
// - opcode       in   6  IR[31:26], sampled in DECODE
// - zero         in   1  ALU zero flag, used in BRANCH
// - pc_load      out  1  PC register load (unconditional, or zero-qualified in BRANCH)
// - ir_load      out  1  IR load; 1 only on last FETCH cycle
// - mdr_load     out  1  MDR load; 1 only on last MEMRD cycle
// - ab_load      out  1  A/B register load (DECODE)
// - aluout_load  out  1  ALUOut load (DECODE, MEMADR, EXEC, ADDIEX)
// - mem_read     out  1  memory read strobe, held for whole access
// - mem_write    out  1  memory write strobe, held for whole access
// - iord         out  1  address mux: 0=PC, 1=ALUOut
// - reg_write    out  1  register-file write
// - regdst       out  1  1=rd, 0=rt;  memtoreg out 1: 1=MDR, 0=ALUOut
// - alusrca      out  1  0=PC, 1=A;   alusrcb out 2: 00=B 01=4 10=signext 11=signext<<2
// - aluop        out  2  00=add 01=sub 10=funct;  pcsrc out 2: 00=ALU 01=ALUOut 10=jump target
// - done         out  1  one-cycle pulse in last state of each instruction
// - illegal      out  1  one-cycle pulse in DECODE on unknown opcode
// BEHAVIOUR
// - Reset: rst==0 at posedge -> state=FETCH, wait_cnt=0. While rst==0 all enables/strobes/pulses
//   (pc_load, ir_load, mdr_load, ab_load, aluout_load, mem_read, mem_write, reg_write, done, illegal)
//   forced 0; selects 0. Reset mid-instruction aborts it; no partial write after rst deasserts.
// - States: FETCH DECODE MEMADR MEMRD MEMWB MEMWR EXEC ALUWB BRANCH JUMP ADDIEX ADDIWB.
// - FETCH: mem_read=1 iord=0 alusrca=0 alusrcb=01 aluop=00 pcsrc=00; ir_load & pc_load on last cycle.
// - DECODE: ab_load=1, aluout_load=1 (alusrca=0 alusrcb=11 aluop=00). Next by opcode:
//   000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX,
//   other->FETCH with illegal=1 and done=1.
// - MEMADR: alusrca=1 alusrcb=10 aluop=00 aluout_load=1; lw->MEMRD, sw->MEMWR (opcode held in IR).
// - MEMRD: mem_read=1 iord=1, mdr_load last cycle -> MEMWB: reg_write=1 regdst=0 memtoreg=1 done.
// - MEMWR: mem_write=1 iord=1 for MEM_LAT cycles, done on last -> FETCH.
// - EXEC: alusrca=1 alusrcb=00 aluop=10 -> ALUWB: reg_write=1 regdst=1 memtoreg=0 done.
// - BRANCH: alusrca=1 alusrcb=00 aluop=01 pcsrc=01 pc_load=zero done. JUMP: pcsrc=10 pc_load=1 done.
// - ADDIEX: alusrca=1 alusrcb=10 aluop=00 -> ADDIWB: reg_write=1 regdst=0 memtoreg=0 done.
// - Wait counter: in FETCH/MEMRD/MEMWR, counts 0..MEM_LAT-1, state advances when cnt==MEM_LAT-1,
//   cnt clears on every state change; MEM_LAT=1 -> single-cycle access, counter constant 0.
// - Latency (L=MEM_LAT): R/addi 3+L, lw 3+2L, sw 2+2L, beq/j 2+L cycles FETCH-entry to next FETCH.
// - All outputs decoded combinationally from state/cnt (Moore), only zero gates pc_load in BRANCH.
// STRUCTURE
// - Shared include mips_defs.vh: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI),
//   state encodings (4-bit), ALUOP_*, ALUSRCB_*, PCSRC_* codes; datapath and bench use the same file.
// - One sub-module: mem_wait_counter (clk, rst, clr, en, last) parameterised by MEM_LAT/CNT_W.
// - State register + next-state always block + output decode block in this module.
// TESTING
// - Reset: hold rst=0 3 cycles with opcode=100011 -> all enables 0; after release FETCH, mem_read=1.
// - MEM_LAT=1, opcode=000000 -> states FETCH,DECODE,EXEC,ALUWB; reg_write=1 regdst=1 cycle 4, done.
// - MEM_LAT=3, opcode=100011 -> ir_load on cycle 3, mdr_load on cycle 8, reg_write+memtoreg cycle 9.
// - opcode=000100: zero=1 -> pc_load=1 pcsrc=01 in BRANCH; repeat zero=0 -> pc_load=0, done=1.
// - opcode=111111 -> illegal=1 and done=1 in DECODE, next state FETCH, no reg_write/mem_write.
// - Reset mid-MEMWR (MEM_LAT=4, rst=0 at 2nd wait cycle) -> mem_write drops same cycle, restarts FETCH.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes,
// FSM state encoding and datapath select codes.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_SEXT  = 2'b10;
  localparam logic [1:0] ALUSRCB_SEXT2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11
  } state_t;

endpackage

// File: rtl/multicycle_control_mem_wait_counter.sv
// Memory wait counter: counts cycles spent in a memory-access state and
// flags the final cycle so the FSM knows when the access completes.
module mem_wait_counter #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] r_cnt;

  // Count up while waiting; cleared on reset and on every state change.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_cnt <= '0;
    end else if (en && !last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // With MEM_LAT=1 this is always true and the counter never leaves 0.
  always_comb begin
    last = (r_cnt == CNT_W'(MEM_LAT - 1));
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath. Memory states
// (FETCH/MEMRD/MEMWR) last MEM_LAT cycles; all outputs decode from state
// plus the wait-counter's last flag, with zero gating pc_load in BRANCH.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_load,
  output logic       ir_load,
  output logic       mdr_load,
  output logic       ab_load,
  output logic       aluout_load,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       done,
  output logic       illegal
);

  state_t r_state;
  state_t w_next;
  logic   w_last;
  logic   w_clr;
  logic   w_en;

  assign w_en  = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
  assign w_clr = (w_next != r_state);

  mem_wait_counter #(
    .MEM_LAT(MEM_LAT),
    .CNT_W  (CNT_W)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_en),
    .last(w_last)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state sequencing; memory states hold until the wait counter expires.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  if (w_last) w_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = ST_EXEC;
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_J:         w_next = ST_JUMP;
          OP_ADDI:      w_next = ST_ADDIEX;
          default:      w_next = ST_FETCH;
        endcase
      end
      ST_MEMADR: w_next = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  if (w_last) w_next = ST_MEMWB;
      ST_MEMWR:  if (w_last) w_next = ST_FETCH;
      ST_EXEC:   w_next = ST_ALUWB;
      ST_ADDIEX: w_next = ST_ADDIWB;
      default:   w_next = ST_FETCH;
    endcase
  end

  // Moore output decode; everything is held at 0 while reset is asserted.
  always_comb begin
    pc_load     = 1'b0;
    ir_load     = 1'b0;
    mdr_load    = 1'b0;
    ab_load     = 1'b0;
    aluout_load = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    reg_write   = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = ALUSRCB_B;
    aluop       = ALUOP_ADD;
    pcsrc       = PCSRC_ALU;
    done        = 1'b0;
    illegal     = 1'b0;
    if (rst) begin
      case (r_state)
        ST_FETCH: begin
          mem_read = 1'b1;
          alusrcb  = ALUSRCB_FOUR;
          ir_load  = w_last;
          pc_load  = w_last;
        end
        ST_DECODE: begin
          ab_load     = 1'b1;
          aluout_load = 1'b1;
          alusrcb     = ALUSRCB_SEXT2;
          if (!(opcode == OP_RTYPE || opcode == OP_LW || opcode == OP_SW ||
                opcode == OP_BEQ || opcode == OP_J || opcode == OP_ADDI)) begin
            illegal = 1'b1;
            done    = 1'b1;
          end
        end
        ST_MEMADR: begin
          alusrca     = 1'b1;
          alusrcb     = ALUSRCB_SEXT;
          aluout_load = 1'b1;
        end
        ST_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          mdr_load = w_last;
        end
        ST_MEMWB: begin
          reg_write = 1'b1;
          memtoreg  = 1'b1;
          done      = 1'b1;
        end
        ST_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          done      = w_last;
        end
        ST_EXEC: begin
          alusrca     = 1'b1;
          aluop       = ALUOP_FUNCT;
          aluout_load = 1'b1;
        end
        ST_ALUWB: begin
          reg_write = 1'b1;
          regdst    = 1'b1;
          done      = 1'b1;
        end
        ST_BRANCH: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = PCSRC_ALUOUT;
          pc_load = zero;
          done    = 1'b1;
        end
        ST_JUMP: begin
          pcsrc   = PCSRC_JUMP;
          pc_load = 1'b1;
          done    = 1'b1;
        end
        ST_ADDIEX: begin
          alusrca     = 1'b1;
          alusrcb     = ALUSRCB_SEXT;
          aluout_load = 1'b1;
        end
        ST_ADDIWB: begin
          reg_write = 1'b1;
          done      = 1'b1;
        end
        default: begin
          pc_load = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: three instances (MEM_LAT 1, 3, 4)
// share inputs; each output word is compared with hand-built signatures.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;

  // Signature layout:
  // {pc_load,ir_load,mdr_load,ab_load,aluout_load, mem_read,mem_write,iord,
  //  reg_write,regdst,memtoreg,alusrca, alusrcb, aluop, pcsrc, done,illegal}
  localparam logic [19:0] S_FETCH   = {5'b00000, 3'b100, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [19:0] S_FETCH_L = {5'b11000, 3'b100, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [19:0] S_DECODE  = {5'b00011, 3'b000, 4'b0000, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam logic [19:0] S_DEC_ILL = {5'b00011, 3'b000, 4'b0000, 2'b11, 2'b00, 2'b00, 2'b11};
  localparam logic [19:0] S_MEMADR  = {5'b00001, 3'b000, 4'b0001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [19:0] S_MEMRD   = {5'b00000, 3'b101, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [19:0] S_MEMRD_L = {5'b00100, 3'b101, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [19:0] S_MEMWB   = {5'b00000, 3'b000, 4'b1010, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [19:0] S_MEMWR   = {5'b00000, 3'b011, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [19:0] S_EXEC    = {5'b00001, 3'b000, 4'b0001, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [19:0] S_ALUWB   = {5'b00000, 3'b000, 4'b1100, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [19:0] S_BR_Z1   = {5'b10000, 3'b000, 4'b0001, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam logic [19:0] S_BR_Z0   = {5'b00000, 3'b000, 4'b0001, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam logic [19:0] S_JUMP    = {5'b10000, 3'b000, 4'b0000, 2'b00, 2'b00, 2'b10, 2'b10};
  localparam logic [19:0] S_ADDIEX  = {5'b00001, 3'b000, 4'b0001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [19:0] S_ADDIWB  = {5'b00000, 3'b000, 4'b1000, 2'b00, 2'b00, 2'b00, 2'b10};

  logic       pc1, ir1, mdr1, ab1, alo1, mr1, mw1, io1, rw1, rd1, m2r1, asa1, dn1, il1;
  logic [1:0] asb1, aop1, pcs1;
  logic       pc3, ir3, mdr3, ab3, alo3, mr3, mw3, io3, rw3, rd3, m2r3, asa3, dn3, il3;
  logic [1:0] asb3, aop3, pcs3;
  logic       pc4, ir4, mdr4, ab4, alo4, mr4, mw4, io4, rw4, rd4, m2r4, asa4, dn4, il4;
  logic [1:0] asb4, aop4, pcs4;
  logic [19:0] sig1, sig3, sig4;

  assign sig1 = {pc1, ir1, mdr1, ab1, alo1, mr1, mw1, io1, rw1, rd1, m2r1, asa1, asb1, aop1, pcs1, dn1, il1};
  assign sig3 = {pc3, ir3, mdr3, ab3, alo3, mr3, mw3, io3, rw3, rd3, m2r3, asa3, asb3, aop3, pcs3, dn3, il3};
  assign sig4 = {pc4, ir4, mdr4, ab4, alo4, mr4, mw4, io4, rw4, rd4, m2r4, asa4, asb4, aop4, pcs4, dn4, il4};

  int errors = 0;
  int checks = 0;

  multicycle_control #(.MEM_LAT(1), .CNT_W(4)) d1 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_load(pc1), .ir_load(ir1), .mdr_load(mdr1), .ab_load(ab1), .aluout_load(alo1),
    .mem_read(mr1), .mem_write(mw1), .iord(io1), .reg_write(rw1), .regdst(rd1),
    .memtoreg(m2r1), .alusrca(asa1), .alusrcb(asb1), .aluop(aop1), .pcsrc(pcs1),
    .done(dn1), .illegal(il1)
  );

  multicycle_control #(.MEM_LAT(3), .CNT_W(4)) d3 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_load(pc3), .ir_load(ir3), .mdr_load(mdr3), .ab_load(ab3), .aluout_load(alo3),
    .mem_read(mr3), .mem_write(mw3), .iord(io3), .reg_write(rw3), .regdst(rd3),
    .memtoreg(m2r3), .alusrca(asa3), .alusrcb(asb3), .aluop(aop3), .pcsrc(pcs3),
    .done(dn3), .illegal(il3)
  );

  multicycle_control #(.MEM_LAT(4), .CNT_W(4)) d4 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_load(pc4), .ir_load(ir4), .mdr_load(mdr4), .ab_load(ab4), .aluout_load(alo4),
    .mem_read(mr4), .mem_write(mw4), .iord(io4), .reg_write(rw4), .regdst(rd4),
    .memtoreg(m2r4), .alusrca(asa4), .alusrcb(asb4), .aluop(aop4), .pcsrc(pcs4),
    .done(dn4), .illegal(il4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two reset edges, then release; afterwards every instance sits in FETCH cycle 1.
  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    opcode = OP_LW;
    zero   = 1'b0;
    rst    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (sig1 !== 20'h0) begin errors++; $display("FAIL reset_l1 cycle %0d: got %h expected %h", i, sig1, 20'h0); end
      checks++;
      if (sig3 !== 20'h0) begin errors++; $display("FAIL reset_l3 cycle %0d: got %h expected %h", i, sig3, 20'h0); end
      checks++;
      if (sig4 !== 20'h0) begin errors++; $display("FAIL reset_l4 cycle %0d: got %h expected %h", i, sig4, 20'h0); end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (sig1 !== S_FETCH_L) begin errors++; $display("FAIL reset_release_l1: got %h expected %h", sig1, S_FETCH_L); end
    checks++;
    if (sig3 !== S_FETCH) begin errors++; $display("FAIL reset_release_l3: got %h expected %h", sig3, S_FETCH); end
  endtask

  task automatic test_rtype();
    logic [19:0] exp [5];
    exp = '{S_FETCH_L, S_DECODE, S_EXEC, S_ALUWB, S_FETCH_L};
    opcode = OP_RTYPE;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (sig1 !== exp[i]) begin errors++; $display("FAIL rtype cycle %0d: got %h expected %h", i + 1, sig1, exp[i]); end
    end
  endtask

  task automatic test_lw_lat3();
    logic [19:0] exp [10];
    exp = '{S_FETCH, S_FETCH, S_FETCH_L, S_DECODE, S_MEMADR,
            S_MEMRD, S_MEMRD, S_MEMRD_L, S_MEMWB, S_FETCH};
    opcode = OP_LW;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (sig3 !== exp[i]) begin errors++; $display("FAIL lw_lat3 cycle %0d: got %h expected %h", i + 1, sig3, exp[i]); end
    end
  endtask

  task automatic test_branch();
    logic [19:0] exp [7];
    exp = '{S_FETCH_L, S_DECODE, S_BR_Z1, S_FETCH_L, S_DECODE, S_BR_Z0, S_FETCH_L};
    opcode = OP_BEQ;
    zero   = 1'b1;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == 3) zero = 1'b0;
      checks++;
      if (sig1 !== exp[i]) begin errors++; $display("FAIL branch cycle %0d: got %h expected %h", i + 1, sig1, exp[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [19:0] exp [3];
    exp = '{S_FETCH_L, S_DEC_ILL, S_FETCH_L};
    opcode = 6'b111111;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (sig1 !== exp[i]) begin errors++; $display("FAIL illegal cycle %0d: got %h expected %h", i + 1, sig1, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp [8];
    exp = '{S_FETCH_L, S_DECODE, S_ADDIEX, S_ADDIWB, S_FETCH_L, S_DECODE, S_JUMP, S_FETCH_L};
    opcode = OP_ADDI;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == 4) opcode = OP_J;
      checks++;
      if (sig1 !== exp[i]) begin errors++; $display("FAIL addi_j cycle %0d: got %h expected %h", i + 1, sig1, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_memwr();
    logic [19:0] exp [8];
    logic [19:0] post [4];
    exp  = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH_L, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR};
    post = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH_L};
    opcode = OP_SW;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (sig4 !== exp[i]) begin errors++; $display("FAIL sw_lat4 cycle %0d: got %h expected %h", i + 1, sig4, exp[i]); end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sig4 !== 20'h0) begin errors++; $display("FAIL memwr_abort: got %h expected %h", sig4, 20'h0); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (sig4 !== post[i]) begin errors++; $display("FAIL memwr_restart cycle %0d: got %h expected %h", i + 1, sig4, post[i]); end
    end
  endtask

  initial begin
    rst    = 1'b0;
    opcode = OP_LW;
    zero   = 1'b0;
    test_reset();
    test_rtype();
    test_lw_lat3();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_reset_mid_memwr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
